// File: rtl/sram_pkg.sv
// Shared types and elaboration-time helpers for the sram_sp_pipe block.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_READY
  } state_t;

  // Number of write-mask lanes needed to cover dw bits.
  function automatic int lane_count(input int dw, input int lane_w);
    return (dw + lane_w - 1) / lane_w;
  endfunction

  // Width of lane i; only the top lane may be narrower than lane_w.
  function automatic int lane_width(input int dw, input int lane_w, input int i);
    int nl;
    nl = lane_count(dw, lane_w);
    return (i == nl - 1) ? dw - (nl - 1) * lane_w : lane_w;
  endfunction

  // Even parity of a lane (callers zero-extend narrower lanes).
  function automatic logic lane_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_lane_bank.sv
// One write-mask lane of sram_sp_pipe: storage, write enable and registered read.
// With SRAM_PARITY_EN defined each word carries an even-parity bit and a
// registered per-lane mismatch flag is produced alongside the read data.
module sram_lane_bank
  import sram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          rd_en,
  input  logic          addr_ok,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
`ifdef SRAM_PARITY_EN
  ,
  output logic          perr
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int SW = W + 1;
`else
  localparam int SW = W;
`endif

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] wword;

`ifdef SRAM_PARITY_EN
  assign wword = {lane_parity(64'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  // Array write port.
  // NOTE: the storage array has no reset; clearing it is the init sequencer's job,
  // and a reset branch here would turn the RAM into a huge flop bank.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wword;
  end

  // Registered read; holds its value between reads, zero for out-of-range addresses.
  always_ff @(posedge clk) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= addr_ok ? mem[addr][W-1:0] : '0;
  end

`ifdef SRAM_PARITY_EN
  // Parity mismatch flag, asserted only in the cycle the read data is presented.
  always_ff @(posedge clk) begin
    if (rst) perr <= 1'b0;
    else     perr <= rd_en && addr_ok && lane_parity(64'(mem[addr]));
  end
`endif

endmodule

// File: rtl/sram_sp_pipe.sv
// Parametrised single-port SRAM with valid/ready requests, per-lane write mask,
// RD_LAT (1 or 2) read latency and optional zero-fill after reset.
// Optional macro SRAM_PARITY_EN adds per-lane even parity and the rsp_err output.
module sram_sp_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH          = 65536,
  parameter int AW             = $clog2(DEPTH),
  parameter int DW             = 23,
  parameter int LANE_W         = 8,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NL            = lane_count(DW, LANE_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [NL-1:0] req_wmask,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done
`ifdef SRAM_PARITY_EN
  ,
  output logic          rsp_err
`endif
);

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic          init_we;
  logic          accept;
  logic          rd_en;
  logic          addr_ok;
  logic          bank_ok;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rd_q;
  logic          s1_valid;
`ifdef SRAM_PARITY_EN
  logic [NL-1:0] lane_err;
`endif

  // Control FSM with registered handshake outputs; walks the init counter in ST_INIT.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == AW'(DEPTH - 1)) begin
            state     <= ST_READY;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_READY: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign init_we  = (state == ST_INIT) && !rst;
  assign accept   = req_valid && req_ready && !rst;
  assign rd_en    = accept && !req_wr;
  assign addr_ok  = ({1'b0, req_addr} < (AW + 1)'(DEPTH));
  assign bank_ok  = init_we || addr_ok;
  assign mem_addr = init_we ? init_cnt : req_addr;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    localparam int LO = i * LANE_W;
    localparam int LW = lane_width(DW, LANE_W, i);

    logic          lane_we;
    logic [LW-1:0] lane_wdata;

    assign lane_we    = init_we || (accept && req_wr && req_wmask[i] && addr_ok);
    assign lane_wdata = init_we ? '0 : req_wdata[LO +: LW];

    sram_lane_bank #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (LW)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (lane_we),
      .rd_en   (rd_en),
      .addr_ok (bank_ok),
      .addr    (mem_addr),
      .wdata   (lane_wdata),
      .rdata   (rd_q[LO +: LW])
`ifdef SRAM_PARITY_EN
      ,
      .perr    (lane_err[i])
`endif
    );
  end

  // First response stage: valid strobe aligned with the registered lane read data.
  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= rd_en;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_valid;
    logic [DW-1:0] s2_rdata;
`ifdef SRAM_PARITY_EN
    logic          s2_err;
`endif

    // Extra output stage; data only advances with a response so it holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_rdata <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_rdata <= rd_q;
      end
    end

`ifdef SRAM_PARITY_EN
    // Error flag follows the same extra stage as the data.
    always_ff @(posedge clk) begin
      if (rst) s2_err <= 1'b0;
      else     s2_err <= |lane_err;
    end
    assign rsp_err = s2_err;
`endif

    assign rsp_valid = s2_valid;
    assign rsp_rdata = s2_rdata;
  end else begin : g_lat1
    assign rsp_valid = s1_valid;
    assign rsp_rdata = rd_q;
`ifdef SRAM_PARITY_EN
    assign rsp_err   = |lane_err;
`endif
  end

endmodule

// File: tb/tb_sram_sp_pipe.sv
// Directed bench for sram_sp_pipe: two instances (RD_LAT=1 and RD_LAT=2, DEPTH=16)
// share one stimulus stream; a latency model checks every response cycle.
module tb_sram_sp_pipe;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 23;
  localparam int NL    = 3;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NL-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_wmask = '0;

  logic          ready1, ready2, v1, v2, done1, done2;
  logic [DW-1:0] d1, d2;
`ifdef SRAM_PARITY_EN
  logic          err1, err2;
`endif

  sram_sp_pipe #(.DEPTH(DEPTH), .DW(DW), .LANE_W(8), .RD_LAT(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(v1), .rsp_rdata(d1), .init_done(done1)
`ifdef SRAM_PARITY_EN
    , .rsp_err(err1)
`endif
  );

  sram_sp_pipe #(.DEPTH(DEPTH), .DW(DW), .LANE_W(8), .RD_LAT(2), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(v2), .rsp_rdata(d2), .init_done(done2)
`ifdef SRAM_PARITY_EN
    , .rsp_err(err2)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected-response model: a read accepted at an edge shows up 1 (u1) or 2 (u2) cycles later.
  logic          mon_en    = 1'b0;
  logic          track_rd  = 1'b0;
  logic [DW-1:0] track_d   = '0;
  logic          track_err = 1'b0;
  logic          q1_v = 1'b0, q2_v = 1'b0, q1_e = 1'b0, q2_e = 1'b0;
  logic [DW-1:0] q1_d = '0, q2_d = '0, hold1 = '0, hold2 = '0;

  always @(posedge clk) begin
    if (rst) begin
      q1_v <= 1'b0; q2_v <= 1'b0; q1_e <= 1'b0; q2_e <= 1'b0;
      hold1 <= '0;  hold2 <= '0;
    end else begin
      if (q1_v) hold1 <= q1_d;
      if (q2_v) hold2 <= q2_d;
      q1_v <= track_rd; q1_d <= track_d; q1_e <= track_err;
      q2_v <= q1_v;     q2_d <= q1_d;    q2_e <= q1_e;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("u1 rsp_valid", 32'(v1), 32'(q1_v));
      check("u1 rsp_rdata", 32'(d1), 32'(q1_v ? q1_d : hold1));
      check("u2 rsp_valid", 32'(v2), 32'(q2_v));
      check("u2 rsp_rdata", 32'(d2), 32'(q2_v ? q2_d : hold2));
`ifdef SRAM_PARITY_EN
      check("u1 rsp_err", 32'(err1), 32'(q1_v & q1_e));
      check("u2 rsp_err", 32'(err2), 32'(q2_v & q2_e));
`endif
    end
  end

  // Present one request for one cycle; caller guarantees req_ready is high.
  task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [NL-1:0] m, input logic [DW-1:0] exp, input logic e);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; req_wmask = m;
    track_rd  = !wr;  track_d = exp; track_err = e;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; track_rd = 1'b0; track_err = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait out an init sweep, checking the handshake stays low for exactly DEPTH cycles.
  task automatic wait_init(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check({tag, " req_ready low"}, 32'({ready1, ready2}), 32'd0);
      check({tag, " init_done low"}, 32'({done1, done2}), 32'd0);
      @(posedge clk);
    end
    #1;
    check({tag, " req_ready high"}, 32'({ready1, ready2}), 32'b11);
    check({tag, " init_done high"}, 32'({done1, done2}), 32'b11);
  endtask

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [NL-1:0] m, input logic [DW-1:0] exp);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.wmask = m; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cleared array reads back zero at every address.
    for (int a = 0; a < DEPTH; a++) add(1'b0, AW'(a), '0, '0, '0);
    // Masked partial write merges lanes.
    add(1'b1, 4'd5, 23'h7ABCDE, 3'b111, '0);
    add(1'b1, 4'd5, 23'h000011, 3'b001, '0);
    add(1'b0, 4'd5, '0, '0, 23'h7ABC11);
    // Back-to-back reads after writes; write-then-read of the same word.
    add(1'b1, 4'd1, 23'h111111, 3'b111, '0);
    add(1'b1, 4'd2, 23'h222222, 3'b111, '0);
    add(1'b1, 4'd3, 23'h333333, 3'b111, '0);
    add(1'b0, 4'd1, '0, '0, 23'h111111);
    add(1'b0, 4'd2, '0, '0, 23'h222222);
    add(1'b0, 4'd3, '0, '0, 23'h333333);
    add(1'b1, 4'd9, 23'h123456, 3'b111, '0);
    add(1'b0, 4'd9, '0, '0, 23'h123456);
    add(1'b1, 4'd9, 23'h7FFFFF, 3'b000, '0);
    add(1'b0, 4'd9, '0, '0, 23'h123456);
    // Narrow top lane and middle lane masking.
    add(1'b1, 4'd10, 23'h7FFFFF, 3'b111, '0);
    add(1'b1, 4'd10, 23'h000000, 3'b100, '0);
    add(1'b0, 4'd10, '0, '0, 23'h00FFFF);
    add(1'b1, 4'd10, 23'h000000, 3'b010, '0);
    add(1'b0, 4'd10, '0, '0, 23'h0000FF);
    // Highest address and untouched neighbours.
    add(1'b1, 4'd15, 23'h5A5A5A, 3'b111, '0);
    add(1'b0, 4'd15, '0, '0, 23'h5A5A5A);
    add(1'b0, 4'd0, '0, '0, '0);
    add(1'b0, 4'd5, '0, '0, 23'h7ABC11);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset req_ready", 32'({ready1, ready2}), 32'd0);
    check("reset init_done", 32'({done1, done2}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init("init");

    foreach (vecs[i])
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].exp, 1'b0);
    idle(4);

    // Reset with reads in flight, then a request held through the re-init sweep.
    drive(1'b0, 4'd1, '0, '0, 23'h111111, 1'b0);
    drive(1'b0, 4'd2, '0, '0, 23'h222222, 1'b0);
    req_valid = 1'b0; track_rd = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
    wait_init("reinit");
    drive(1'b0, 4'd5, '0, '0, '0, 1'b0);
    idle(4);

`ifdef SRAM_PARITY_EN
    drive(1'b1, 4'd3, 23'h0000FF, 3'b111, '0, 1'b0);
    idle(1);
    u1.g_lane[0].u_bank.mem[3][0] = ~u1.g_lane[0].u_bank.mem[3][0];
    u2.g_lane[0].u_bank.mem[3][0] = ~u2.g_lane[0].u_bank.mem[3][0];
    drive(1'b0, 4'd3, '0, '0, 23'h0000FE, 1'b1);
    drive(1'b0, 4'd7, '0, '0, '0, 1'b0);
    idle(4);
`endif

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
